sync_fifo_cmd_dispatch: RTL and testbench
=========================================

Name: sync_fifo_cmd_dispatch

Overview:
- Read-side consumer placed directly downstream of sync_fifo.
- Pops one packed command from the FIFO. Each command is {len, addr}.
- Expands the command into len+1 address beats on a valid/ready output stream, with the address incrementing by one each beat.
- Chains commands back-to-back with no bubble while the FIFO is non-empty.

Parameters:
- CMD_LENGTH, 10, width of a FIFO command word. Must equal LEN_W + ADDR_W.
- LEN_W, 4, width of the length field (command bits [CMD_LENGTH-1:ADDR_W]). Beats per command = len + 1.
- ADDR_W, 6, width of the start-address field (command bits [ADDR_W-1:0]).

Ports:
- clk  input  1  Clock. All logic is on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- i_soft_reset  input  1  Synchronous clear. Same effect as reset.
- i_fifo_empty  input  1  FIFO empty flag.
- i_fifo_cmd  input  CMD_LENGTH  FIFO head word. Valid whenever i_fifo_empty = 0.
- o_fifo_get_en  output  1  FIFO pop strobe. Combinational, one cycle per command.
- o_valid  output  1  Beat valid. Registered.
- i_ready  input  1  Downstream accepts the beat.
- o_addr  output  ADDR_W  Beat address. Registered.
- o_last  output  1  Final beat of the current command. Registered.
- o_cmd_done  output  1  One-cycle pulse in the cycle after the last beat handshakes.
- o_busy  output  1  High while state = BURST.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). No asynchronous reset path.
- Reset and i_soft_reset have priority over all other activity. State goes to IDLE, remaining count to 0, and o_valid, o_addr, o_last, o_cmd_done all go to 0. o_fifo_get_en is forced to 0 in any cycle where reset or i_soft_reset is high. An in-flight burst is abandoned and its remaining beats are dropped.
- Internal state: FSM {IDLE, BURST}; rem counter [LEN_W-1:0]; address register.
- IDLE: when i_fifo_empty = 0:
  - o_fifo_get_en = 1.
  - Next cycle: o_addr = cmd[ADDR_W-1:0], rem = cmd len field, o_last = (len == 0), o_valid = 1, state = BURST.
- Latency: FIFO non-empty in cycle N gives first beat valid in cycle N+1.
- BURST: o_valid = 1.
  - While i_ready = 0, o_addr, o_last and o_valid hold stable. No pop occurs.
  - Handshake with o_last = 0: o_addr <= o_addr + 1, wrapping modulo 2^ADDR_W (63 -> 0). rem <= rem - 1. o_last <= (rem == 1).
  - Handshake with o_last = 1 and i_fifo_empty = 0: o_fifo_get_en = 1 in the same cycle, and the next command loads immediately. Stay in BURST with no idle cycle.
  - Handshake with o_last = 1 and i_fifo_empty = 1: o_valid <= 0, state <= IDLE.
- o_cmd_done: registered. High exactly one cycle after each o_last handshake.
- Pop rules:
  - o_fifo_get_en is never asserted while i_fifo_empty = 1.
  - At most one pop per command.
  - Never pop in BURST unless the last beat is handshaking in that cycle.
- Sustained throughput: 1 beat per cycle with i_ready held high.
- len = max (15) gives 16 beats. The rem counter never underflows.

Test Plan:
- Single command len=3, addr=5, i_ready = 1 → o_fifo_get_en pulses 1 cycle. o_addr = 5, 6, 7, 8 on consecutive cycles starting 1 cycle after pop. o_last only on 8. o_cmd_done pulses the next cycle. o_valid = 0 afterward.
- Backpressure: len=1, addr=10, i_ready toggling 0, 0, 1, 0, 1 → o_addr holds 10 through the stalls. Beats 10, 11 accepted exactly once each. No extra pop.
- Address wrap: len=3, addr=62 → beats 62, 63, 0, 1. o_last on 1.
- Back-to-back: FIFO holds {len=0, addr=3} and {len=1, addr=20} → beats 3(last), 20, 21(last) on 3 consecutive cycles. The second o_fifo_get_en coincides with the handshake of beat 3.
- Empty FIFO held for 20 cycles → o_fifo_get_en, o_valid and o_busy stay 0.
- i_soft_reset during beat 2 of a len=7 command → next cycle o_valid = 0, o_busy = 0, o_last = 0, o_addr = 0, no pop in the soft-reset cycle. The next queued command then dispatches normally from its start address.

Source files
------------

// File: rtl/sync_fifo_cmd_dispatch.sv
// Pops {len, addr} commands from a synchronous FIFO and expands each command
// into len+1 incrementing-address beats on a valid/ready stream.
module sync_fifo_cmd_dispatch #(
  parameter int CMD_LENGTH = 10,
  parameter int LEN_W      = 4,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_soft_reset,
  input  logic                  i_fifo_empty,
  input  logic [CMD_LENGTH-1:0] i_fifo_cmd,
  output logic                  o_fifo_get_en,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_last,
  output logic                  o_cmd_done,
  output logic                  o_busy
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    rem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q;
  logic                last_q;
  logic                done_q;

  logic                clr;
  logic                hs;
  logic                pop;
  logic [LEN_W-1:0]    cmd_len;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W-1:0]   addr_d;
  logic [LEN_W-1:0]    rem_d;

  assign clr      = reset | i_soft_reset;
  assign hs       = valid_q & i_ready;
  assign cmd_len  = i_fifo_cmd[CMD_LENGTH-1:ADDR_W];
  assign cmd_addr = i_fifo_cmd[ADDR_W-1:0];
  assign addr_d   = addr_q + ADDR_W'(1);
  assign rem_d    = rem_q - LEN_W'(1);

  // Pop when idle, or when the final beat of the current command completes,
  // so consecutive commands chain without a bubble.
  assign pop = ~clr & ~i_fifo_empty &
               ((state_q == IDLE) | (hs & last_q));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= hs & last_q;
      if (pop) begin
        state_q <= BURST;
        addr_q  <= cmd_addr;
        rem_q   <= cmd_len;
        last_q  <= (cmd_len == '0);
        valid_q <= 1'b1;
      end else if (hs && !last_q) begin
        addr_q  <= addr_d;
        rem_q   <= rem_d;
        last_q  <= (rem_q == LEN_W'(1));
      end else if (hs && last_q) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign o_fifo_get_en = pop;
  assign o_valid       = valid_q;
  assign o_addr        = addr_q;
  assign o_last        = last_q;
  assign o_cmd_done    = done_q;
  assign o_busy        = (state_q == BURST);

endmodule

// File: tb/tb_sync_fifo_cmd_dispatch.sv
// Directed bench for sync_fifo_cmd_dispatch; a queue stands in for the FIFO.
module tb_sync_fifo_cmd_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_soft_reset;
  logic        i_fifo_empty;
  logic [9:0]  i_fifo_cmd;
  logic        o_fifo_get_en;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_addr;
  logic        o_last;
  logic        o_cmd_done;
  logic        o_busy;

  sync_fifo_cmd_dispatch #(.CMD_LENGTH(10), .LEN_W(4), .ADDR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_soft_reset (i_soft_reset),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_cmd   (i_fifo_cmd),
    .o_fifo_get_en(o_fifo_get_en),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_addr       (o_addr),
    .o_last       (o_last),
    .o_cmd_done   (o_cmd_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int          vecs  = 0;
  int          fails = 0;
  logic [9:0]  q[$];
  logic [10:0] obs;
  logic        pop_now;

  // Packed view: {get_en, valid, last, cmd_done, busy, addr[5:0]}
  function automatic logic [10:0] pk(bit g, bit v, bit l, bit d, bit b, int a);
    return {g, v, l, d, b, 6'(a)};
  endfunction

  function automatic logic [9:0] cmd(int len, int addr);
    return {4'(len), 6'(addr)};
  endfunction

  // Apply inputs just after the falling edge and sample outputs 1ns later.
  task automatic drive(input logic rdy, input logic srst, input logic rst);
    reset        = rst;
    i_soft_reset = srst;
    i_ready      = rdy;
    i_fifo_empty = (q.size() == 0);
    i_fifo_cmd   = (q.size() == 0) ? 10'd0 : q[0];
    #1;
    obs     = {o_fifo_get_en, o_valid, o_last, o_cmd_done, o_busy, o_addr};
    pop_now = o_fifo_get_en;
  endtask

  task automatic advance();
    @(negedge clk);
    if (pop_now && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    q.push_back(cmd(0, 9));
    drive(1'b1, 1'b0, 1'b1);
    advance();
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) q.delete();
      if (c == 4) q.push_back(cmd(0, 9));
      if (c == 5) q.delete();
      drive(1'b1, (c == 4), (c <= 2));
      exp = pk(0, 0, 0, 0, 0, 0);
      vecs++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL reset c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_single();
    logic [10:0] exp[7];
    exp = '{pk(1,0,0,0,0,0), pk(0,1,0,0,1,5), pk(0,1,0,0,1,6), pk(0,1,0,0,1,7),
            pk(0,1,1,0,1,8), pk(0,0,0,1,0,8), pk(0,0,0,0,0,8)};
    q.push_back(cmd(3, 5));
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      vecs++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL single c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp[c]);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] exp[8];
    logic        rdy[8];
    exp = '{pk(1,0,0,0,0,8), pk(0,1,0,0,1,10), pk(0,1,0,0,1,10), pk(0,1,0,0,1,10),
            pk(0,1,1,0,1,11), pk(0,1,1,0,1,11), pk(0,0,0,1,0,11), pk(0,0,0,0,0,11)};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    q.push_back(cmd(1, 10));
    for (int c = 0; c < 8; c++) begin
      drive(rdy[c], 1'b0, 1'b0);
      vecs++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL backpressure c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp[c]);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [10:0] exp[7];
    exp = '{pk(1,0,0,0,0,11), pk(0,1,0,0,1,62), pk(0,1,0,0,1,63), pk(0,1,0,0,1,0),
            pk(0,1,1,0,1,1), pk(0,0,0,1,0,1), pk(0,0,0,0,0,1)};
    q.push_back(cmd(3, 62));
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      vecs++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL wrap c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp[c]);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp[6];
    exp = '{pk(1,0,0,0,0,1), pk(1,1,1,0,1,3), pk(0,1,0,1,1,20),
            pk(0,1,1,0,1,21), pk(0,0,0,1,0,21), pk(0,0,0,0,0,21)};
    q.push_back(cmd(0, 3));
    q.push_back(cmd(1, 20));
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      vecs++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL back_to_back c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp[c]);
      end
      advance();
    end
  endtask

  task automatic test_empty_idle();
    logic [10:0] exp;
    exp = pk(0, 0, 0, 0, 0, 21);
    for (int c = 0; c < 20; c++) begin
      drive(c[0], 1'b0, 1'b0);
      vecs++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL empty_idle c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_soft_reset();
    logic [10:0] exp[8];
    exp = '{pk(1,0,0,0,0,21), pk(0,1,0,0,1,40), pk(0,1,0,0,1,41), pk(1,0,0,0,0,0),
            pk(0,1,0,0,1,50), pk(0,1,0,0,1,51), pk(0,1,1,0,1,52), pk(0,0,0,1,0,52)};
    q.push_back(cmd(7, 40));
    q.push_back(cmd(2, 50));
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, (c == 2), 1'b0);
      vecs++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL soft_reset c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp[c]);
      end
      advance();
    end
  endtask

  task automatic test_max_len();
    logic [10:0] exp;
    q.push_back(cmd(15, 0));
    for (int c = 0; c < 19; c++) begin
      if (c == 0)       exp = pk(1, 0, 0, 0, 0, 52);
      else if (c <= 16) exp = pk(0, 1, (c == 16), 0, 1, c - 1);
      else if (c == 17) exp = pk(0, 0, 0, 1, 0, 15);
      else              exp = pk(0, 0, 0, 0, 0, 15);
      drive(1'b1, 1'b0, 1'b0);
      vecs++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL max_len c%0d {get,vld,last,done,busy,addr} got %b want %b", c, obs, exp);
      end
      advance();
    end
  endtask

  initial begin
    reset        = 1'b1;
    i_soft_reset = 1'b0;
    i_ready      = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_cmd   = '0;
    pop_now      = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_empty_idle();
    test_soft_reset();
    test_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
